// File: rtl/val2_shifter_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | val2_shifter_pipe: ARM addressing-mode-1 Val2/carry generator, 1-2 stage |
// | valid/ready pipeline with flush.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module val2_shifter_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              I,
  input  logic              bypass_rm,
  input  logic              reg_shift,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [7:0]        Val_Rs,
  input  logic [11:0]       Shift_operand,
  input  logic              C_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Val2,
  output logic              C_out
);

  localparam int              LW      = $clog2(DATA_W);
  localparam int              AW      = LW + 1;
  localparam logic [AW-1:0]   AMT_W   = AW'(DATA_W);
  localparam logic [AW-1:0]   AMT_SAT = AW'(DATA_W + 1);
  localparam logic [1:0]      SH_LSL  = 2'd0;
  localparam logic [1:0]      SH_LSR  = 2'd1;
  localparam logic [1:0]      SH_ASR  = 2'd2;
  localparam logic [1:0]      SH_ROR  = 2'd3;

  logic              dec_rrx;
  logic [1:0]        dec_type;
  logic [AW-1:0]     dec_amt;
  logic [DATA_W-1:0] dec_rm;
  logic [4:0]        shift_imm;
  logic [1:0]        so_type;
  logic [LW-1:0]     rs_mod;

  assign shift_imm = Shift_operand[11:7];
  assign so_type   = Shift_operand[6:5];
  assign rs_mod    = Val_Rs[LW-1:0];

  // Every mode is folded into one (type, amount) form: amount 0 means
  // "pass Rm with C_in", and ROR by exactly W yields Rm with C=Rm[W-1].
  always_comb begin
    dec_rrx  = 1'b0;
    dec_type = so_type;
    dec_amt  = '0;
    dec_rm   = Val_Rm;
    if (bypass_rm) begin
      dec_type = SH_LSL;
      dec_rm   = DATA_W'(Shift_operand);
    end else if (I) begin
      dec_type = SH_ROR;
      dec_rm   = DATA_W'(Shift_operand[7:0]);
      dec_amt  = AW'({Shift_operand[11:8], 1'b0});
    end else if (reg_shift) begin
      if (Val_Rs == 8'd0)
        dec_amt = '0;
      else if (so_type == SH_ROR)
        dec_amt = (rs_mod == '0) ? AMT_W : AW'(rs_mod);
      else if (Val_Rs > 8'(DATA_W))
        dec_amt = AMT_SAT;
      else
        dec_amt = AW'(Val_Rs);
    end else begin
      dec_amt = AW'(shift_imm);
      if (shift_imm == 5'd0) begin
        if (so_type == SH_LSR || so_type == SH_ASR)
          dec_amt = AMT_W;
        dec_rrx = (so_type == SH_ROR);
      end
    end
  end

  // Returns {carry, value}; shifts run one bit wider so the carry falls out.
  function automatic logic [DATA_W:0] shift_exec(
    input logic              rrx,
    input logic [1:0]        typ,
    input logic [AW-1:0]     amt,
    input logic [DATA_W-1:0] rm,
    input logic              cin
  );
    logic [DATA_W:0]   res;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] rot;
    logic [AW-1:0]     asr_amt;
    res     = {cin, rm};
    wide    = '0;
    rot     = '0;
    asr_amt = '0;
    if (rrx) begin
      res = {rm[0], cin, rm[DATA_W-1:1]};
    end else if (amt != '0) begin
      case (typ)
        SH_LSL: begin
          wide = {1'b0, rm} << amt;
          res  = wide;
        end
        SH_LSR: begin
          wide = {rm, 1'b0} >> amt;
          res  = {wide[0], wide[DATA_W:1]};
        end
        SH_ASR: begin
          asr_amt = (amt > AMT_W) ? AMT_W : amt;
          wide    = $signed({rm, 1'b0}) >>> asr_amt;
          res     = {wide[0], wide[DATA_W:1]};
        end
        default: begin
          rot = (rm >> amt) | (rm << (AMT_W - amt));
          res = {rot[DATA_W-1], rot};
        end
      endcase
    end
    return res;
  endfunction

  if (PIPE_STAGES == 2) begin : g_two
    logic              v1_q, v2_q;
    logic              s1_rrx_q, s1_cin_q;
    logic [1:0]        s1_type_q;
    logic [AW-1:0]     s1_amt_q;
    logic [DATA_W-1:0] s1_rm_q;
    logic [DATA_W:0]   res_d, res_q;
    logic              adv2, take1;

    assign adv2     = !v2_q || out_ready;
    assign take1    = !v1_q || adv2;
    assign res_d    = shift_exec(s1_rrx_q, s1_type_q, s1_amt_q, s1_rm_q, s1_cin_q);
    assign in_ready = take1;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q      <= 1'b0;
        v2_q      <= 1'b0;
        s1_rrx_q  <= 1'b0;
        s1_cin_q  <= 1'b0;
        s1_type_q <= '0;
        s1_amt_q  <= '0;
        s1_rm_q   <= '0;
        res_q     <= '0;
      end else begin
        if (flush) begin
          v1_q <= 1'b0;
          v2_q <= 1'b0;
        end else begin
          if (take1) v1_q <= in_valid;
          if (adv2)  v2_q <= v1_q;
          if (take1 && in_valid) begin
            s1_rrx_q  <= dec_rrx;
            s1_cin_q  <= C_in;
            s1_type_q <= dec_type;
            s1_amt_q  <= dec_amt;
            s1_rm_q   <= dec_rm;
          end
          if (adv2 && v1_q) res_q <= res_d;
        end
      end
    end

    assign out_valid = v2_q;
    assign Val2      = res_q[DATA_W-1:0];
    assign C_out     = res_q[DATA_W];
  end else begin : g_one
    logic            v_q;
    logic [DATA_W:0] res_d, res_q;
    logic            adv;

    assign adv      = !v_q || out_ready;
    assign res_d    = shift_exec(dec_rrx, dec_type, dec_amt, dec_rm, C_in);
    assign in_ready = adv;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        res_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= in_valid;
        if (in_valid) res_q <= res_d;
      end
    end

    assign out_valid = v_q;
    assign Val2      = res_q[DATA_W-1:0];
    assign C_out     = res_q[DATA_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_val2_shifter_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_val2_shifter_pipe: bench for a 32-bit/2-stage and a 64-bit/1-stage    |
// | instance against a bit-level reference model. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module tb_val2_shifter_pipe;

  typedef struct {
    bit          i;
    bit          byp;
    bit          rsh;
    logic [63:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;
    bit          cin;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_I = 0, a_byp = 0, a_rsh = 0;
  logic [31:0] a_rm = '0, a_val;
  logic [7:0]  a_rsv = '0;
  logic [11:0] a_so = '0;
  logic        a_cin = 0, a_out_valid, a_out_ready = 1, a_cout;

  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_I = 0, b_byp = 0, b_rsh = 0;
  logic [63:0] b_rm = '0, b_val;
  logic [7:0]  b_rsv = '0;
  logic [11:0] b_so = '0;
  logic        b_cin = 0, b_out_valid, b_out_ready = 1, b_cout;

  int passed = 0, total = 0;
  int nout_a = 0, nout_b = 0;
  logic [64:0] qa[$], qb[$];
  op_t pa, pb;
  bit a_dir = 0, b_dir = 0, a_pushed = 0, b_pushed = 0, a_saw_low = 0;
  logic [64:0] a_exp = '0, b_exp = '0;

  always #5 clk = ~clk;

  val2_shifter_pipe #(.DATA_W(32), .PIPE_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .I(a_I), .bypass_rm(a_byp), .reg_shift(a_rsh), .Val_Rm(a_rm), .Val_Rs(a_rsv),
    .Shift_operand(a_so), .C_in(a_cin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .Val2(a_val), .C_out(a_cout));

  val2_shifter_pipe #(.DATA_W(64), .PIPE_STAGES(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .I(b_I), .bypass_rm(b_byp), .reg_shift(b_rsh), .Val_Rm(b_rm), .Val_Rs(b_rsv),
    .Shift_operand(b_so), .C_in(b_cin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .Val2(b_val), .C_out(b_cout));

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ror1(input logic [63:0] v, input int s, input int W);
    logic [63:0] r = v;
    for (int k = 0; k < s; k++) r = (r >> 1) | (64'(r[0]) << (W - 1));
    return r;
  endfunction

  function automatic logic [63:0] asr1(input logic [63:0] v, input int s, input int W);
    logic [63:0] r = v;
    for (int k = 0; k < s; k++) r = (r >> 1) | (64'(r[W-1]) << (W - 1));
    return r;
  endfunction

  // Reference: {carry, value} straight from the addressing-mode-1 rules.
  function automatic logic [64:0] model(input int W, input op_t o);
    logic [63:0] m, rm, v;
    bit c;
    int s, n, t;
    m  = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    rm = o.rm & m;
    t  = int'(o.so[6:5]);
    v  = rm;
    c  = o.cin;
    if (o.byp) begin
      v = 64'(o.so);
    end else if (o.i) begin
      s = 2 * int'(o.so[11:8]);
      v = ror1(64'(o.so[7:0]), s, W);
      c = (s == 0) ? o.cin : v[W-1];
    end else if (o.rsh) begin
      n = int'(o.rs);
      if (n != 0) begin
        case (t)
          0: if (n < W) begin v = (rm << n) & m; c = rm[W-n]; end
             else begin v = 0; c = (n == W) ? rm[0] : 1'b0; end
          1: if (n < W) begin v = rm >> n; c = rm[n-1]; end
             else begin v = 0; c = (n == W) ? rm[W-1] : 1'b0; end
          2: if (n < W) begin v = asr1(rm, n, W); c = rm[n-1]; end
             else begin v = rm[W-1] ? m : 64'h0; c = rm[W-1]; end
          default: begin
            s = n % W;
            if (s == 0) begin v = rm; c = rm[W-1]; end
            else begin v = ror1(rm, s, W); c = rm[s-1]; end
          end
        endcase
      end
    end else begin
      s = int'(o.so[11:7]);
      case (t)
        0: if (s != 0) begin v = (rm << s) & m; c = rm[W-s]; end
        1: if (s == 0) begin v = 0; c = rm[W-1]; end
           else begin v = rm >> s; c = rm[s-1]; end
        2: if (s == 0) begin v = rm[W-1] ? m : 64'h0; c = rm[W-1]; end
           else begin v = asr1(rm, s, W); c = rm[s-1]; end
        default:
           if (s == 0) begin v = (rm >> 1) | (64'(o.cin) << (W - 1)); c = rm[0]; end
           else begin v = ror1(rm, s, W); c = rm[s-1]; end
      endcase
    end
    return {c, v};
  endfunction

  function automatic op_t mk(input bit i, input bit byp, input bit rsh, input logic [63:0] rm,
                             input logic [7:0] rs, input logic [11:0] so, input bit cin);
    op_t o;
    o.i = i; o.byp = byp; o.rsh = rsh; o.rm = rm; o.rs = rs; o.so = so; o.cin = cin;
    return o;
  endfunction

  function automatic op_t rand_op(input int W);
    op_t o;
    int sel = $urandom_range(0, 9);
    o.byp = (sel == 0);
    o.i   = (sel <= 3);
    o.rsh = (sel >= 6) || ($urandom_range(0, 3) == 0);
    o.rm  = {$urandom, $urandom};
    o.so  = 12'($urandom);
    o.cin = 1'($urandom);
    case ($urandom_range(0, 5))
      0: o.rs = 8'd0;
      1: o.rs = 8'(W - 1);
      2: o.rs = 8'(W);
      3: o.rs = 8'(W + 1);
      4: o.rs = 8'(2 * W + $urandom_range(0, 3));
      default: o.rs = 8'($urandom);
    endcase
    return o;
  endfunction

  task automatic drive_a(input op_t o);
    pa = o; a_I = o.i; a_byp = o.byp; a_rsh = o.rsh;
    a_rm = o.rm[31:0]; a_rsv = o.rs; a_so = o.so; a_cin = o.cin;
  endtask

  task automatic drive_b(input op_t o);
    pb = o; b_I = o.i; b_byp = o.byp; b_rsh = o.rsh;
    b_rm = o.rm; b_rsv = o.rs; b_so = o.so; b_cin = o.cin;
  endtask

  // One clock: check handshakes/results just before the edge, update the
  // scoreboards, then confirm stalled outputs held across the edge.
  task automatic step();
    bit ha, hb, era, erb;
    logic [32:0] sa;
    logic [64:0] sb, e;
    ha = 0; hb = 0; sa = '0; sb = '0;
    a_pushed = 0; b_pushed = 0;
    #1;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      era = !(qa.size() >= 2 && !a_out_ready);
      chk("a_in_ready", 66'(a_in_ready), 66'(era));
      if (a_in_valid && !a_in_ready) a_saw_low = 1;
      if (a_out_valid && qa.size() == 0) chk("a_spurious", 66'(a_out_valid), 66'(0));
      else if (a_out_valid && a_out_ready) begin
        e = qa.pop_front();
        chk("a_result", 66'({a_cout, 32'h0, a_val}), 66'(e));
        nout_a++;
      end
      ha = a_out_valid && !a_out_ready && !a_flush;
      sa = {a_cout, a_val};
      if (a_flush) qa.delete();
      else if (a_in_valid && era) begin
        qa.push_back(a_dir ? a_exp : model(32, pa));
        a_pushed = 1;
      end

      erb = !(qb.size() >= 1 && !b_out_ready);
      chk("b_in_ready", 66'(b_in_ready), 66'(erb));
      if (b_out_valid && qb.size() == 0) chk("b_spurious", 66'(b_out_valid), 66'(0));
      else if (b_out_valid && b_out_ready) begin
        e = qb.pop_front();
        chk("b_result", 66'({b_cout, b_val}), 66'(e));
        nout_b++;
      end
      hb = b_out_valid && !b_out_ready && !b_flush;
      sb = {b_cout, b_val};
      if (b_flush) qb.delete();
      else if (b_in_valid && erb) begin
        qb.push_back(b_dir ? b_exp : model(64, pb));
        b_pushed = 1;
      end
    end
    @(posedge clk);
    #1;
    if (ha && !rst) chk("a_hold", 66'({a_out_valid, a_cout, a_val}), 66'({1'b1, sa}));
    if (hb && !rst) chk("b_hold", 66'({b_out_valid, b_cout, b_val}), 66'({1'b1, sb}));
  endtask

  task automatic drain();
    a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    for (int k = 0; k < 12; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      step();
    end
    chk("drain_a", 66'(qa.size()), 66'(0));
    chk("drain_b", 66'(qb.size()), 66'(0));
  endtask

  task automatic send_a(input op_t o, input logic [64:0] exp);
    drive_a(o); a_exp = exp; a_dir = 1; a_in_valid = 1;
    step();
    a_in_valid = 0; a_dir = 0;
  endtask

  task automatic send_b(input op_t o, input logic [64:0] exp);
    drive_b(o); b_exp = exp; b_dir = 1; b_in_valid = 1;
    step();
    b_in_valid = 0; b_dir = 0;
  endtask

  initial begin
    int n0, sent;
    rst = 1;
    step();
    step();
    chk("a_rst_ov",  66'(a_out_valid), 66'(0));
    chk("a_rst_val", 66'({a_cout, a_val}), 66'(0));
    chk("a_rst_rdy", 66'(a_in_ready), 66'(1));
    chk("b_rst_ov",  66'(b_out_valid), 66'(0));
    chk("b_rst_val", 66'({b_cout, b_val}), 66'(0));
    chk("b_rst_rdy", 66'(b_in_ready), 66'(1));
    rst = 0;

    send_a(mk(1, 0, 0, 0, 0, 12'h4FF, 1), {1'b1, 64'hFF00_0000});
    chk("a_lat_early", 66'(a_out_valid), 66'(0));
    step();
    chk("a_lat", 66'(a_out_valid), 66'(1));
    drain();
    send_a(mk(1, 0, 0, 0, 0, 12'h0FF, 0), {1'b0, 64'hFF});                 drain();
    send_a(mk(0, 0, 0, 64'h8000_0001, 0, 12'h020, 1), {1'b1, 64'h0});       drain();
    send_a(mk(0, 0, 0, 64'h8000_0001, 0, 12'h040, 1), {1'b1, 64'hFFFF_FFFF}); drain();
    send_a(mk(0, 0, 0, 64'h8000_0001, 0, 12'h060, 1), {1'b1, 64'hC000_0000}); drain();
    send_a(mk(0, 0, 0, 64'h8000_0001, 0, 12'h200, 1), {1'b0, 64'h10});      drain();
    send_a(mk(0, 0, 1, 64'hF, 8'd0,  12'h020, 0), {1'b0, 64'hF});           drain();
    send_a(mk(0, 0, 1, 64'hF, 8'd32, 12'h000, 0), {1'b1, 64'h0});           drain();
    send_a(mk(0, 0, 1, 64'hF, 8'd33, 12'h000, 1), {1'b0, 64'h0});           drain();
    send_a(mk(0, 0, 1, 64'hF, 8'd36, 12'h060, 0), {1'b1, 64'hF000_0000});   drain();
    send_a(mk(0, 0, 1, 64'h8000_0000, 8'd32, 12'h020, 0), {1'b1, 64'h0});   drain();
    send_a(mk(1, 1, 1, 0, 0, 12'hABC, 1), {1'b1, 64'hABC});                 drain();

    send_b(mk(0, 0, 0, 64'h8000_0000_0000_0000, 0, 12'h020, 0), {1'b1, 64'h0});
    chk("b_lat", 66'(b_out_valid), 66'(1));
    drain();
    send_b(mk(0, 1, 0, 0, 0, 12'hABC, 0), {1'b0, 64'hABC});                 drain();

    // 8-op stream with the consumer stalled for cycles 3..6
    n0 = nout_a; sent = 0;
    for (int t = 0; t < 40; t++) begin
      if (sent >= 8 && t > 6) break;
      a_out_ready = !(t >= 3 && t <= 6);
      a_in_valid  = (sent < 8);
      if (sent < 8) drive_a(rand_op(32));
      step();
      if (a_pushed) sent++;
    end
    drain();
    chk("bp_count", 66'(nout_a - n0), 66'(8));
    chk("bp_stall", 66'(a_saw_low), 66'(1));

    for (int k = 0; k < 150; k++) begin
      drive_a(rand_op(32));
      drive_b(rand_op(64));
      a_in_valid  = ($urandom_range(0, 9) < 8);
      b_in_valid  = ($urandom_range(0, 9) < 8);
      a_out_ready = ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    // flush with two ops held in flight and a third presented
    n0 = nout_a;
    a_out_ready = 0; a_in_valid = 1;
    drive_a(rand_op(32)); step();
    drive_a(rand_op(32)); step();
    drive_a(rand_op(32)); a_flush = 1; step();
    a_flush = 0; a_in_valid = 0;
    chk("flush_ov", 66'(a_out_valid), 66'(0));
    a_out_ready = 1;
    for (int k = 0; k < 5; k++) step();
    chk("flush_none", 66'(nout_a - n0), 66'(0));

    // flush coinciding with an output transfer: that one result still counts
    n0 = nout_a;
    a_out_ready = 0; a_in_valid = 1;
    drive_a(rand_op(32)); step();
    drive_a(rand_op(32)); step();
    a_in_valid = 0; a_out_ready = 1; a_flush = 1; step();
    a_flush = 0;
    for (int k = 0; k < 5; k++) step();
    chk("flush_xfer", 66'(nout_a - n0), 66'(1));

    // reset mid-stream
    a_out_ready = 1; a_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      drive_a(rand_op(32));
      step();
    end
    rst = 1; step(); rst = 0; a_in_valid = 0;
    chk("rst_mid_ov",  66'(a_out_valid), 66'(0));
    chk("rst_mid_val", 66'({a_cout, a_val}), 66'(0));
    chk("rst_mid_rdy", 66'(a_in_ready), 66'(1));
    for (int k = 0; k < 4; k++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/val2_shifter_pipe.md
# val2_shifter_pipe

Parametrised, pipelined successor to the Val2 operand generator for the ARM968E-S core. It produces the second ALU operand (Val2) and the shifter carry-out from Rm, an optional register shift amount (Rs) or an immediate encoding, covering full ARM addressing-mode-1 semantics. These include RRX, the #0-means-W encodings and register-specified shifts. It sits between the ID/EXE boundary and the ALU, behind a valid/ready handshake with a flush input for branch squashing.

## Interface
- DATA_W, 32: operand width; power of two, 32 or 64.
- PIPE_STAGES, 2: register stages, 1 or 2; latency equals this value.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- I  in  1  immediate-rotate mode.
- bypass_rm  in  1  memory-offset mode: Val2 = zero-extended Shift_operand.
- reg_shift  in  1  shift amount taken from Val_Rs[7:0] instead of Shift_operand[11:7].
- Val_Rm  in  DATA_W  Rm value.
- Val_Rs  in  8  Rs[7:0].
- Shift_operand  in  12  instruction bits [11:0].
- C_in  in  1  current CPSR C flag.
- out_valid  out  1  Val2/C_out valid.
- out_ready  in  1  ALU accepts the result.
- Val2  out  DATA_W  generated operand.
- C_out  out  1  shifter carry-out.

## Operation
- Field decode: immed_8 = SO[7:0]; rotate_imm = SO[11:8]; shift_imm = SO[11:7]; type = SO[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); n = Val_Rs[7:0] when reg_shift=1.
- Mode priority is bypass_rm, then I, then reg_shift, then immediate shift.
- bypass_rm=1: Val2 = {0, SO}; C_out = C_in.
- I=1: Val2 = zero-extended immed_8 rotated right by 2*rotate_imm within DATA_W. C_out = C_in if rotate_imm=0, else Val2[DATA_W-1].
- Immediate shift, LSL: #0 gives Rm with C_in. Otherwise Rm<<s with C = Rm[W-s].
- Immediate shift, LSR: #0 means shift by W, giving 0 with C = Rm[W-1]. Otherwise Rm>>s with C = Rm[s-1].
- Immediate shift, ASR: #0 means shift by W, giving all bits = Rm[W-1] with C = Rm[W-1]. Otherwise arithmetic shift with C = Rm[s-1].
- Immediate shift, ROR: #0 is RRX, Val2 = {C_in, Rm[W-1:1]} with C = Rm[0]. Otherwise rotate right by s with C = Rm[s-1].
- Register shift, n=0 (any type): Val2 = Rm, C_out = C_in.
- Register shift, LSL: n<W gives Rm<<n with C = Rm[W-n]. n=W gives 0 with C = Rm[0]. n>W gives 0 with C = 0.
- Register shift, LSR: n<W gives Rm>>n with C = Rm[n-1]. n=W gives 0 with C = Rm[W-1]. n>W gives 0 with C = 0.
- Register shift, ASR: n<W is a normal arithmetic shift. n>=W gives all bits = Rm[W-1] with C = Rm[W-1].
- Register shift, ROR: r = n mod W. r=0 gives Rm with C = Rm[W-1]. Otherwise rotate right by r with C = Rm[r-1].
- Pipeline split, PIPE_STAGES=2: stage 1 registers the decoded mode, the effective amount (saturated to W+1), type, Rm and C_in. Stage 2 registers Val2 and C_out.
- Pipeline split, PIPE_STAGES=1: the single stage registers Val2 and C_out.

## Timing
- Reset: all stage valid bits clear; out_valid=0, Val2=0, C_out=0, in_ready=1 on the cycle after rst.
- Transfer: an input transfer occurs when in_valid && in_ready. The result appears with out_valid=1 exactly PIPE_STAGES cycles later if no stall occurs.
- Stall: each stage advances when it is empty or its successor advances. in_ready = stage-1 empty or stage 1 advances. Throughput is 1 operation/cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, Val2 and C_out hold stable. in_ready falls only once every stage is full.
- flush: all valid bits clear on the next edge and data registers keep their values. An input presented in the same cycle as flush is discarded. An output transfer coinciding with flush still counts.
- rst overrides flush and handshakes. rst mid-operation drops everything in flight.
- Ordering: results leave in input order; no reordering, no combinational in→out path.

## Test plan
- Reset, then I=1, SO=0x4FF (rotate_imm=4, immed_8=0xFF), C_in=1 -> after 2 cycles Val2=0xFF000000, C_out=1. Same operation with SO=0x0FF -> Val2=0x000000FF, C_out=C_in.
- Immediate shifts with Rm=0x80000001, C_in=1:
  - LSR #0 -> 0, C=1.
  - ASR #0 -> 0xFFFFFFFF, C=1.
  - ROR #0 (RRX) -> 0xC0000000, C=1.
  - LSL #4 -> 0x00000010, C=0.
- reg_shift=1, Rm=0x0000000F:
  - Rs=0 -> Rm with C_in.
  - LSL Rs=32 -> 0, C=1.
  - LSL Rs=33 -> 0, C=0.
  - ROR Rs=36 -> 0xF0000000, C=1.
- Back-to-back stream of 8 ops, out_ready low for cycles 3-6 -> Val2 held stable, in_ready low once full, all 8 results in order with no loss or duplication.
- flush asserted with 2 ops in flight and in_valid high -> out_valid=0 next cycle, none of the 3 ops ever emerge. rst asserted mid-stream -> all outputs 0 the next cycle.
- DATA_W=64, PIPE_STAGES=1, LSR #0 on Rm=0x8000000000000000 -> Val2=0, C=1 after 1 cycle; bypass_rm=1, SO=0xABC -> Val2=0xABC.
